// File: rtl/md_defs.sv
// Shared definitions for the HI/LO multiply/divide unit.
// The control unit encodes md_op with these same constants.
package md_defs;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    // IDLE means no operation is in flight; RUN means the busy countdown is active
    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    // True for the ops that occupy the unit for a multi-cycle busy period
    function automatic logic is_md_class(input logic [2:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

endpackage

// File: rtl/md_latency_counter.sv
// Busy-period countdown for the multiply/divide unit.
// Loads the operation latency, decrements to zero, flags the final busy cycle.
module md_latency_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [3:0] loadValue_i,
    output logic       zero_o,
    output logic       last_o
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // Next count: a load wins, otherwise count down until zero is reached
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = loadValue_i;
        end else if (count_q != 4'd0) begin
            count_d = count_q - 4'd1;
        end
    end

    // Count register with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == 4'd0);
    assign last_o = (count_q == 4'd1);

endmodule

// File: rtl/hilo_md_unit.sv
// Execute-stage multiply/divide unit owning the HI/LO registers.
// Results are computed on the start-cycle operands, parked in shadow
// registers, and committed to HI/LO when the busy countdown expires.
module hilo_md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        HILO_busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    import md_defs::*;

    md_state_e   state_q;
    md_state_e   state_d;
    logic [31:0] hi_q;
    logic [31:0] hi_d;
    logic [31:0] lo_q;
    logic [31:0] lo_d;
    logic [31:0] shadowHi_q;
    logic [31:0] shadowHi_d;
    logic [31:0] shadowLo_q;
    logic [31:0] shadowLo_d;

    logic        accept;
    logic        mdStart;
    logic [3:0]  loadValue;
    logic        cntZero;
    logic        cntLast;

    logic signed [63:0] prodS;
    logic        [63:0] prodU;
    logic signed [31:0] quotS;
    logic signed [31:0] remS;
    logic        [31:0] quotU;
    logic        [31:0] remU;
    logic               divOverflow;

    // Ops arriving while an operation is in flight are dropped
    assign accept  = start && (state_q == MD_IDLE);
    assign mdStart = accept && is_md_class(md_op);

    assign loadValue = ((md_op == MD_MULT) || (md_op == MD_MULTU)) ?
                       4'(MULT_CYCLES) : 4'(DIV_CYCLES);

    md_latency_counter u_counter (
        .clk         (clk),
        .reset       (reset),
        .load_i      (mdStart),
        .loadValue_i (loadValue),
        .zero_o      (cntZero),
        .last_o      (cntLast)
    );

    // The start term is masked by reset so a stall is never requested while clearing
    assign HILO_busy = (start && reset && is_md_class(md_op)) || !cntZero;

    // Operands are sign- or zero-extended to 64 bits so the full product is kept
    assign prodS = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prodU = {32'd0, A} * {32'd0, B};

    assign quotS = $signed(A) / $signed(B);
    assign remS  = $signed(A) % $signed(B);
    assign quotU = A / B;
    assign remU  = A % B;

    // The one signed quotient that does not fit in 32 bits
    assign divOverflow = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

    // Shadow results are captured only in the cycle an operation is accepted
    always_comb begin
        shadowHi_d = shadowHi_q;
        shadowLo_d = shadowLo_q;
        if (mdStart) begin
            case (md_op)
                MD_MULT: begin
                    shadowHi_d = prodS[63:32];
                    shadowLo_d = prodS[31:0];
                end
                MD_MULTU: begin
                    shadowHi_d = prodU[63:32];
                    shadowLo_d = prodU[31:0];
                end
                MD_DIV: begin
                    if (B == 32'd0) begin
                        shadowHi_d = hi_q;
                        shadowLo_d = lo_q;
                    end else if (divOverflow) begin
                        shadowHi_d = 32'd0;
                        shadowLo_d = 32'h8000_0000;
                    end else begin
                        shadowHi_d = remS;
                        shadowLo_d = quotS;
                    end
                end
                MD_DIVU: begin
                    if (B == 32'd0) begin
                        shadowHi_d = hi_q;
                        shadowLo_d = lo_q;
                    end else begin
                        shadowHi_d = remU;
                        shadowLo_d = quotU;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // FSM next state: enter RUN on a multi-cycle op, leave on the final busy cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (mdStart) state_d = MD_RUN;
            MD_RUN:  if (cntLast) state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    // HI/LO next values: commit the shadow at the end of RUN, or take a move in IDLE
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if ((state_q == MD_RUN) && cntLast) begin
            hi_d = shadowHi_q;
            lo_d = shadowLo_q;
        end else if (accept && (md_op == MD_MTHI)) begin
            hi_d = A;
        end else if (accept && (md_op == MD_MTLO)) begin
            lo_d = A;
        end
    end

    // All architectural and shadow state with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= MD_IDLE;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            shadowHi_q <= 32'd0;
            shadowLo_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            shadowHi_q <= shadowHi_d;
            shadowLo_q <= shadowLo_d;
        end
    end

    assign HI = hi_q;
    assign LO = lo_q;

endmodule

// File: tb/tb_hilo_md_unit.sv
// Directed self-checking bench for hilo_md_unit.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_hilo_md_unit;

    import md_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        HILO_busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] curHi  = 32'd0;
    logic [31:0] curLo  = 32'd0;

    hilo_md_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .A         (A),
        .B         (B),
        .HILO_busy (HILO_busy),
        .HI        (HI),
        .LO        (LO)
    );

    always #5 clk = ~clk;

    // Counts one comparison and reports it if the observed value is wrong
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = s;
        md_op = op;
        A     = a;
        B     = b;
        #1;
    endtask

    // Issues one op, counts busy cycles (bounded), then checks the committed HI/LO
    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int expBusy, input logic [31:0] expHi, input logic [31:0] expLo);
        int busyCycles;
        busyCycles = 0;
        applyStimulus(1'b1, op, a, b);
        while (HILO_busy && (busyCycles < 40)) begin
            busyCycles++;
            checkOutput({tag, " HI held"}, HI, curHi);
            checkOutput({tag, " LO held"}, LO, curLo);
            nextCycle();
            applyStimulus(1'b0, MD_NONE, 32'd0, 32'd0);
        end
        if (busyCycles == 0) begin
            nextCycle();
            applyStimulus(1'b0, MD_NONE, 32'd0, 32'd0);
        end
        checkOutput({tag, " busy cycles"}, 32'(busyCycles), 32'(expBusy));
        checkOutput({tag, " HI"}, HI, expHi);
        checkOutput({tag, " LO"}, LO, expLo);
        curHi = expHi;
        curLo = expLo;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, MD_NONE, 32'd0, 32'd0);
        nextCycle();
        nextCycle();

        // A multi-cycle request while reset is low must not raise busy
        applyStimulus(1'b1, MD_MULT, 32'd5, 32'd7);
        checkOutput("busy during reset", {31'd0, HILO_busy}, 32'd0);
        nextCycle();
        reset = 1'b1;
        applyStimulus(1'b0, MD_NONE, 32'd0, 32'd0);
        checkOutput("reset busy", {31'd0, HILO_busy}, 32'd0);
        checkOutput("reset HI", HI, 32'd0);
        checkOutput("reset LO", LO, 32'd0);

        runOp("MULT -2*3",      MD_MULT,  32'hFFFF_FFFE, 32'd3,        6,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
        runOp("MULTU max*2",    MD_MULTU, 32'hFFFF_FFFF, 32'd2,        6,  32'h0000_0001, 32'hFFFF_FFFE);
        runOp("DIV -7/2",       MD_DIV,   32'hFFFF_FFF9, 32'd2,        11, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("MTHI",           MD_MTHI,  32'h0000_1234, 32'd0,        0,  32'h0000_1234, 32'hFFFF_FFFD);
        runOp("MTLO",           MD_MTLO,  32'h0000_5678, 32'd0,        0,  32'h0000_1234, 32'h0000_5678);
        runOp("DIVU by zero",   MD_DIVU,  32'd100,       32'd0,        11, 32'h0000_1234, 32'h0000_5678);
        runOp("DIVU 100/7",     MD_DIVU,  32'd100,       32'd7,        11, 32'd2,         32'd14);
        runOp("DIV 7/-2",       MD_DIV,   32'd7,         32'hFFFF_FFFE, 11, 32'd1,        32'hFFFF_FFFD);
        runOp("DIV overflow",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 11, 32'd0,        32'h8000_0000);
        runOp("MULT max*-1",    MD_MULT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 6,  32'hFFFF_FFFF, 32'h8000_0001);
        runOp("MULTU max*max",  MD_MULTU, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 6,  32'h7FFF_FFFE, 32'h8000_0001);
        runOp("op NONE",        MD_NONE,  32'h1111_1111, 32'h2222_2222, 0,  32'h7FFF_FFFE, 32'h8000_0001);
        runOp("op unknown",     3'd7,     32'h3333_3333, 32'h4444_4444, 0,  32'h7FFF_FFFE, 32'h8000_0001);

        // Abandon a divide with reset low in cycle 4 and confirm no late commit
        applyStimulus(1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2);
        checkOutput("abort start busy", {31'd0, HILO_busy}, 32'd1);
        nextCycle();
        applyStimulus(1'b0, MD_NONE, 32'd0, 32'd0);
        nextCycle();
        nextCycle();
        nextCycle();
        reset = 1'b0;
        nextCycle();
        reset = 1'b1;
        #1;
        checkOutput("abort busy", {31'd0, HILO_busy}, 32'd0);
        checkOutput("abort HI", HI, 32'd0);
        checkOutput("abort LO", LO, 32'd0);
        for (int i = 0; i < 12; i++) begin
            nextCycle();
            checkOutput("abort no commit busy", {31'd0, HILO_busy}, 32'd0);
            checkOutput("abort no commit HI", HI, 32'd0);
            checkOutput("abort no commit LO", LO, 32'd0);
        end
        curHi = 32'd0;
        curLo = 32'd0;

        // A move followed immediately by a multiply in the very next cycle
        runOp("MTLO cafebabe",   MD_MTLO, 32'hCAFE_BABE, 32'd0,  0, 32'd0, 32'hCAFE_BABE);
        runOp("MULT after MTLO", MD_MULT, 32'h0000_0010, 32'h20, 6, 32'd0, 32'h0000_0200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
